// File: rtl/rv_ctl.sv
// rv_ctl: multicycle control FSM for the simple RISC-V core.
//
// Decodes the IR contents supplied by the datapath and sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for the supported subset
// (R-type ALU, I-type ALU, LW, SW, BEQ, BNE, JAL). Any other encoding
// parks the FSM in HALT with trap raised until reset.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   instr             IR contents from the datapath
//   zero              ALU result-is-zero flag (combinational)
//   imem_ready        instruction word valid this cycle
//   dmem_ready        data access completes this cycle
//   pcsourse..mdrwrite single-bit datapath strobes and selects
//   wbsel, immsel     2-bit datapath selects
//   alusel            4-bit ALU operation
//   dmem_re, dmem_we  level data-memory read / write requests
//   trap              illegal instruction, core halted
//   retired           count of completed instructions (wraps)
//   state_dbg         current state encoding
module rv_ctl #(
    parameter int unsigned DPWIDTH = 32,
    parameter int unsigned CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic               regwen,
    output logic               asel,
    output logic               bsel,
    output logic               mdrwrite,
    output logic [1:0]         wbsel,
    output logic [1:0]         immsel,
    output logic [3:0]         alusel,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic               trap,
    output logic [CNTW-1:0]    retired,
    output logic [2:0]         state_dbg
);

    // Select encodings shared with the datapath.
    localparam logic       PC_PLUS4  = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd0;
    localparam logic [1:0] IMM_S     = 2'd1;
    localparam logic [1:0] IMM_B     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;
    localparam logic       ALUA_REG  = 1'b0;
    localparam logic       ALUA_PCC  = 1'b1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   retired_q, retired_d;

    // Instruction field decode
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, legal;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    assign unused_instr_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);
    assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_br  = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
    assign is_jal = (opcode == 7'b1101111);
    assign legal  = is_r | is_i | is_lw | is_sw | is_br | is_jal;

    // funct3 -> ALU op. sub_en only applies to R-type; I-type 000 is always ADD.
    function automatic logic [3:0] alu_op(logic [2:0] f3, logic sub_en, logic sra_en);
        logic [3:0] op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        state_d  = state_q;
        pcsourse = PC_PLUS4;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        mdrwrite = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        wbsel    = WB_ALUOUT;
        immsel   = IMM_L;
        asel     = ALUA_REG;
        bsel     = ALUB_IMM;
        alusel   = ALU_ADD;

        case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    irwrite  = 1'b1;
                    pcwrite  = 1'b1;
                    pccen    = 1'b1;
                    pcsourse = PC_PLUS4;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Precompute the branch/jump target into aluout.
                asel    = ALUA_PCC;
                bsel    = ALUB_IMM;
                alusel  = ALU_ADD;
                immsel  = is_jal ? IMM_J : IMM_B;
                state_d = legal ? StExec : StHalt;
            end
            StExec: begin
                if (is_r) begin
                    asel    = ALUA_REG;
                    bsel    = ALUB_REG;
                    alusel  = alu_op(funct3, alt, alt);
                    state_d = StWb;
                end else if (is_i) begin
                    bsel    = ALUB_IMM;
                    immsel  = IMM_L;
                    alusel  = alu_op(funct3, 1'b0, alt);
                    state_d = StWb;
                end else if (is_lw || is_sw) begin
                    alusel  = ALU_ADD;
                    bsel    = ALUB_IMM;
                    immsel  = is_sw ? IMM_S : IMM_L;
                    state_d = StMem;
                end else if (is_br) begin
                    asel     = ALUA_REG;
                    bsel     = ALUB_REG;
                    alusel   = ALU_SUB;
                    pcsourse = PC_ALU;
                    // BEQ (funct3[0]=0) takes on zero, BNE on ~zero.
                    pcwrite  = zero ^ funct3[0];
                    state_d  = StFetch;
                end else if (is_jal) begin
                    pcwrite  = 1'b1;
                    pcsourse = PC_ALU;
                    regwen   = 1'b1;
                    wbsel    = WB_PC;
                    state_d  = StFetch;
                end else begin
                    state_d = StHalt;
                end
            end
            StMem: begin
                if (is_lw) begin
                    dmem_re = 1'b1;
                    if (dmem_ready) begin
                        mdrwrite = 1'b1;
                        state_d  = StWb;
                    end
                end else begin
                    dmem_we = 1'b1;
                    if (dmem_ready) begin
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                regwen  = 1'b1;
                wbsel   = is_lw ? WB_MDR : WB_ALUOUT;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase

        // No write may complete while reset is held, even mid-instruction.
        if (!rst) begin
            pcwrite  = 1'b0;
            pccen    = 1'b0;
            irwrite  = 1'b0;
            regwen   = 1'b0;
            mdrwrite = 1'b0;
            dmem_re  = 1'b0;
            dmem_we  = 1'b0;
        end
    end

    // Retire on every return to FETCH from a completing state.
    always_comb begin
        retired_d = retired_q;
        if ((state_q == StExec || state_q == StMem || state_q == StWb) &&
            (state_d == StFetch)) begin
            retired_d = retired_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign trap      = (state_q == StHalt);
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rv_ctl.sv
// Bench for rv_ctl: per-cycle expected control vectors are queued with
// their stimulus and compared as the FSM steps. A second instance with a
// 4-bit retire counter checks wrap-around.
module tb_rv_ctl;

    localparam logic       PC_PLUS4  = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd0;
    localparam logic [1:0] IMM_S     = 2'd1;
    localparam logic [1:0] IMM_B     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;
    localparam logic       ALUA_REG  = 1'b0;
    localparam logic       ALUA_PCC  = 1'b1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_LW   = 32'h0000_A103;
    localparam logic [31:0] I_SW   = 32'h0020_A223;
    localparam logic [31:0] I_BEQ  = 32'h0000_0463;
    localparam logic [31:0] I_BNE  = 32'h0000_1463;
    localparam logic [31:0] I_JAL  = 32'h0080_006F;

    typedef struct packed {
        logic [2:0] st;
        logic       trap;
        logic       pcs, pcw, pcc, irw, rgw, asel, bsel, mdrw;
        logic [1:0] wb, imm;
        logic [3:0] alu;
        logic       re, we;
    } ctl_t;

    typedef struct {
        logic ir;
        logic dr;
        logic z;
        ctl_t exp;
        ctl_t msk;
    } step_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero, imem_ready, dmem_ready;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, asel, bsel, mdrwrite;
    logic [1:0]  wbsel, immsel;
    logic [3:0]  alusel;
    logic        dmem_re, dmem_we, trap;
    logic [31:0] retired;
    logic [2:0]  state_dbg;
    logic [21:0] d4_unused_ctl;
    logic [3:0]  d4_retired;

    step_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ret;

    rv_ctl u_dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pcsourse   (pcsourse),
        .pcwrite    (pcwrite),
        .pccen      (pccen),
        .irwrite    (irwrite),
        .regwen     (regwen),
        .asel       (asel),
        .bsel       (bsel),
        .mdrwrite   (mdrwrite),
        .wbsel      (wbsel),
        .immsel     (immsel),
        .alusel     (alusel),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .trap       (trap),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    rv_ctl #(.DPWIDTH(32), .CNTW(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pcsourse   (d4_unused_ctl[0]),
        .pcwrite    (d4_unused_ctl[1]),
        .pccen      (d4_unused_ctl[2]),
        .irwrite    (d4_unused_ctl[3]),
        .regwen     (d4_unused_ctl[4]),
        .asel       (d4_unused_ctl[5]),
        .bsel       (d4_unused_ctl[6]),
        .mdrwrite   (d4_unused_ctl[7]),
        .wbsel      (d4_unused_ctl[9:8]),
        .immsel     (d4_unused_ctl[11:10]),
        .alusel     (d4_unused_ctl[15:12]),
        .dmem_re    (d4_unused_ctl[16]),
        .dmem_we    (d4_unused_ctl[17]),
        .trap       (d4_unused_ctl[18]),
        .retired    (d4_retired),
        .state_dbg  (d4_unused_ctl[21:19])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t sample_ctl();
        ctl_t c;
        c.st = state_dbg;  c.trap = trap;
        c.pcs = pcsourse;  c.pcw = pcwrite;  c.pcc = pccen;  c.irw = irwrite;
        c.rgw = regwen;    c.asel = asel;    c.bsel = bsel;  c.mdrw = mdrwrite;
        c.wb = wbsel;      c.imm = immsel;   c.alu = alusel;
        c.re = dmem_re;    c.we = dmem_we;
        return c;
    endfunction

    // Expected-vector model, one builder per state.
    function automatic ctl_t e_dflt(logic [2:0] st);
        ctl_t c;
        c = '0;
        c.st = st;  c.pcs = PC_PLUS4;  c.wb = WB_ALUOUT;  c.imm = IMM_L;
        c.asel = ALUA_REG;  c.bsel = ALUB_IMM;  c.alu = ALU_ADD;
        return c;
    endfunction

    function automatic ctl_t e_fetch(logic rdy);
        ctl_t c = e_dflt(3'd0);
        if (rdy) begin
            c.irw = 1'b1;  c.pcw = 1'b1;  c.pcc = 1'b1;
        end
        return c;
    endfunction

    function automatic ctl_t e_decode(logic jal);
        ctl_t c = e_dflt(3'd1);
        c.asel = ALUA_PCC;
        c.imm  = jal ? IMM_J : IMM_B;
        return c;
    endfunction

    function automatic ctl_t e_exec_alu(logic r, logic [3:0] op);
        ctl_t c = e_dflt(3'd2);
        c.bsel = r ? ALUB_REG : ALUB_IMM;
        c.alu  = op;
        return c;
    endfunction

    function automatic ctl_t e_exec_ls(logic sw);
        ctl_t c = e_dflt(3'd2);
        c.imm = sw ? IMM_S : IMM_L;
        return c;
    endfunction

    function automatic ctl_t e_exec_br(logic take);
        ctl_t c = e_dflt(3'd2);
        c.bsel = ALUB_REG;  c.alu = ALU_SUB;  c.pcs = PC_ALU;  c.pcw = take;
        return c;
    endfunction

    function automatic ctl_t e_exec_jal();
        ctl_t c = e_dflt(3'd2);
        c.pcw = 1'b1;  c.pcs = PC_ALU;  c.rgw = 1'b1;  c.wb = WB_PC;
        return c;
    endfunction

    function automatic ctl_t e_mem(logic load, logic rdy);
        ctl_t c = e_dflt(3'd3);
        c.re = load;  c.we = !load;  c.mdrw = load & rdy;
        return c;
    endfunction

    function automatic ctl_t e_wb(logic load);
        ctl_t c = e_dflt(3'd4);
        c.rgw = 1'b1;
        c.wb  = load ? WB_MDR : WB_ALUOUT;
        return c;
    endfunction

    function automatic ctl_t e_halt();
        ctl_t c = e_dflt(3'd5);
        c.trap = 1'b1;
        return c;
    endfunction

    function automatic ctl_t m_all();
        ctl_t c = '1;
        return c;
    endfunction

    // Operand selects are don't-care while in MEM.
    function automatic ctl_t m_mem();
        ctl_t c = '1;
        c.asel = 1'b0;  c.bsel = 1'b0;  c.imm = 2'b00;  c.alu = 4'b0000;
        return c;
    endfunction

    function automatic void push(logic ir, logic dr, logic z, ctl_t e, ctl_t m);
        step_t s;
        s.ir = ir;  s.dr = dr;  s.z = z;  s.exp = e;  s.msk = m;
        sb.push_back(s);
    endfunction

    function automatic void push_alu(logic r, logic [3:0] op);
        push(1'b1, 1'b1, 1'b0, e_fetch(1'b1), m_all());
        push(1'b1, 1'b1, 1'b0, e_decode(1'b0), m_all());
        push(1'b1, 1'b1, 1'b0, e_exec_alu(r, op), m_all());
        push(1'b1, 1'b1, 1'b0, e_wb(1'b0), m_all());
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;  imem_ready = 1'b0;  dmem_ready = 1'b0;  zero = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_reset();
        ctl_t got;
        step_t s;
        rst = 1'b0;  imem_ready = 1'b1;  dmem_ready = 1'b1;  zero = 1'b0;
        instr = I_ADDI;  exp_ret = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            got = sample_ctl();
            n_checks++;
            if (got !== e_dflt(3'd0)) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, got, e_dflt(3'd0));
            end
        end
        n_checks++;
        if (retired !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_retired: got %0d expected 0", retired);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        got = sample_ctl();
        n_checks++;
        if (got !== e_fetch(1'b1)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", got, e_fetch(1'b1));
        end
        push(1'b1, 1'b1, 1'b0, e_decode(1'b0), m_all());
        push(1'b1, 1'b1, 1'b0, e_exec_alu(1'b0, ALU_ADD), m_all());
        push(1'b1, 1'b1, 1'b0, e_wb(1'b0), m_all());
        exp_ret++;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
            #1;
            got = sample_ctl();
            n_checks++;
            if ((got & s.msk) !== (s.exp & s.msk)) begin
                n_fail++;
                $display("FAIL reset_addi: got %h expected %h", got, s.exp);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (retired !== exp_ret) begin
            n_fail++;
            $display("FAIL reset_addi_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins [12] = '{32'h0020_8033, 32'h4020_8033, 32'h0020_9033, 32'h0020_A033,
                                  32'h0020_B033, 32'h0020_C033, 32'h0020_D033, 32'h4020_D033,
                                  32'h0020_E033, 32'h0020_F033, 32'h4000_8093, 32'h4010_D093};
        logic [3:0]  ops [12] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                                  ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ADD, ALU_SRA};
        ctl_t got;
        step_t s;
        for (int n = 0; n < 12; n++) begin
            instr = ins[n];
            // Stall one FETCH cycle on the first entry to exercise imem_ready=0.
            if (n == 0) push(1'b0, 1'b1, 1'b0, e_fetch(1'b0), m_all());
            push_alu(n < 10, ops[n]);
            exp_ret++;
            while (sb.size() > 0) begin
                s = sb.pop_front();
                @(negedge clk);
                imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
                #1;
                got = sample_ctl();
                n_checks++;
                if ((got & s.msk) !== (s.exp & s.msk)) begin
                    n_fail++;
                    $display("FAIL alu[%0d] %h: got %h expected %h", n, ins[n], got, s.exp);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (retired !== exp_ret) begin
                n_fail++;
                $display("FAIL alu_retired[%0d]: got %0d expected %0d", n, retired, exp_ret);
            end
        end
    endtask

    task automatic test_lw();
        ctl_t got;
        step_t s;
        instr = I_LW;
        push(1'b1, 1'b0, 1'b0, e_fetch(1'b1), m_all());
        push(1'b1, 1'b0, 1'b0, e_decode(1'b0), m_all());
        push(1'b1, 1'b0, 1'b0, e_exec_ls(1'b0), m_all());
        push(1'b1, 1'b0, 1'b0, e_mem(1'b1, 1'b0), m_mem());
        push(1'b1, 1'b0, 1'b0, e_mem(1'b1, 1'b0), m_mem());
        push(1'b1, 1'b1, 1'b0, e_mem(1'b1, 1'b1), m_mem());
        push(1'b1, 1'b0, 1'b0, e_wb(1'b1), m_all());
        exp_ret++;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
            #1;
            got = sample_ctl();
            n_checks++;
            if ((got & s.msk) !== (s.exp & s.msk)) begin
                n_fail++;
                $display("FAIL lw: got %h expected %h", got, s.exp);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (retired !== exp_ret) begin
            n_fail++;
            $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins  [5] = '{I_BEQ, I_BEQ, I_BNE, I_BNE, I_JAL};
        logic        zs   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        take [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ctl_t got;
        step_t s;
        for (int n = 0; n < 5; n++) begin
            instr = ins[n];
            push(1'b1, 1'b1, zs[n], e_fetch(1'b1), m_all());
            push(1'b1, 1'b1, zs[n], e_decode(n == 4), m_all());
            push(1'b1, 1'b1, zs[n], (n == 4) ? e_exec_jal() : e_exec_br(take[n]), m_all());
            exp_ret++;
            while (sb.size() > 0) begin
                s = sb.pop_front();
                @(negedge clk);
                imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
                #1;
                got = sample_ctl();
                n_checks++;
                if ((got & s.msk) !== (s.exp & s.msk)) begin
                    n_fail++;
                    $display("FAIL branch[%0d]: got %h expected %h", n, got, s.exp);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (retired !== exp_ret || state_dbg !== 3'd0) begin
                n_fail++;
                $display("FAIL branch_done[%0d]: retired %0d state %0d expected %0d state 0",
                         n, retired, state_dbg, exp_ret);
            end
        end
    endtask

    task automatic test_sw_halt();
        ctl_t got;
        step_t s;
        do_reset();
        instr = I_SW;
        push(1'b1, 1'b1, 1'b0, e_fetch(1'b1), m_all());
        push(1'b1, 1'b1, 1'b0, e_decode(1'b0), m_all());
        push(1'b1, 1'b1, 1'b0, e_exec_ls(1'b1), m_all());
        push(1'b1, 1'b1, 1'b0, e_mem(1'b0, 1'b1), m_mem());
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
            #1;
            got = sample_ctl();
            n_checks++;
            if ((got & s.msk) !== (s.exp & s.msk)) begin
                n_fail++;
                $display("FAIL sw: got %h expected %h", got, s.exp);
            end
        end
        exp_ret++;
        @(posedge clk);
        #1;
        instr = 32'h0000_0000;
        push(1'b1, 1'b1, 1'b1, e_fetch(1'b1), m_all());
        push(1'b1, 1'b1, 1'b1, e_decode(1'b0), m_all());
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, e_halt(), m_all());
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
            #1;
            got = sample_ctl();
            n_checks++;
            if ((got & s.msk) !== (s.exp & s.msk)) begin
                n_fail++;
                $display("FAIL halt: got %h expected %h", got, s.exp);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (retired !== exp_ret || trap !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_frozen: retired %0d trap %b expected %0d trap 1",
                     retired, trap, exp_ret);
        end
    endtask

    task automatic test_wrap();
        ctl_t got;
        step_t s;
        do_reset();
        instr = I_ADDI;
        for (int n = 0; n < 17; n++) begin
            push_alu(1'b0, ALU_ADD);
            exp_ret++;
            while (sb.size() > 0) begin
                s = sb.pop_front();
                @(negedge clk);
                imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
                #1;
                got = sample_ctl();
                n_checks++;
                if ((got & s.msk) !== (s.exp & s.msk)) begin
                    n_fail++;
                    $display("FAIL wrap_addi[%0d]: got %h expected %h", n, got, s.exp);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (d4_retired !== exp_ret[3:0] || retired !== exp_ret) begin
                n_fail++;
                $display("FAIL wrap_retired[%0d]: got %0d/%0d expected %0d/%0d",
                         n, d4_retired, retired, exp_ret[3:0], exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        ctl_t got;
        step_t s;
        instr = I_SW;
        push(1'b1, 1'b0, 1'b0, e_fetch(1'b1), m_all());
        push(1'b1, 1'b0, 1'b0, e_decode(1'b0), m_all());
        push(1'b1, 1'b0, 1'b0, e_exec_ls(1'b1), m_all());
        push(1'b1, 1'b0, 1'b0, e_mem(1'b0, 1'b0), m_mem());
        push(1'b1, 1'b0, 1'b0, e_mem(1'b0, 1'b0), m_mem());
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            imem_ready = s.ir;  dmem_ready = s.dr;  zero = s.z;
            #1;
            got = sample_ctl();
            n_checks++;
            if ((got & s.msk) !== (s.exp & s.msk)) begin
                n_fail++;
                $display("FAIL mid_store: got %h expected %h", got, s.exp);
            end
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_ret = '0;
        #1;
        got = sample_ctl();
        n_checks++;
        if (got !== e_dflt(3'd0) || retired !== exp_ret) begin
            n_fail++;
            $display("FAIL mid_store_reset: got %h retired %0d expected %h retired 0",
                     got, retired, e_dflt(3'd0));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        got = sample_ctl();
        n_checks++;
        if (got !== e_fetch(1'b1)) begin
            n_fail++;
            $display("FAIL mid_store_release: got %h expected %h", got, e_fetch(1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_branch();
        test_sw_halt();
        test_wrap();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
